decode_regfile: RTL and testbench

Operand-fetch/decode stage placed directly upstream of the 8-bit ALU. Accepts 8-bit instructions over a valid/ready handshake and holds a 4-entry register file. It drives the ALU's `ra`, `rb` and `opcode` from a registered output slot, and takes the ALU result back through a writeback port. A per-register pending scoreboard stalls issue on read-after-write and write-after-write hazards.

---
 rtl/decode_regfile.sv | 129 ++++++++++++
 tb/tb_decode_regfile.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// Operand-fetch/decode stage: 4-entry register file, pending scoreboard and a registered ALU operand slot.
// Define DECODE_BYPASS_EN to let a same-cycle writeback resolve hazards and forward into operand reads.
module decode_regfile #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [7:0]        instr,
   output logic              instr_ready,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [2:0]        opcode,
   output logic [1:0]        dest,
   input  logic              wb_en,
   input  logic [1:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              halted
);

   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] regs_d [4];
   logic [3:0]        pend_q, pend_d;
   logic              op_valid_q, op_valid_d;
   logic [DATA_W-1:0] ra_q, ra_d, rb_q, rb_d;
   logic [2:0]        opcode_q, opcode_d;
   logic [1:0]        dest_q, dest_d;
   logic              halted_q, halted_d;

   logic              is_alu, is_li, is_halt;
   logic [1:0]        rs1, rs2, rd;
   logic [3:0]        resolved, blocked;
   logic              hazard, accept;
   logic [DATA_W-1:0] rs1_val, rs2_val;

   assign is_alu  = ~instr[7];
   assign is_li   = (instr[7:6] == 2'b10);
   assign is_halt = (instr == 8'hFF);
   assign rs1     = instr[3:2];
   assign rs2     = instr[1:0];
   assign rd      = instr[5:4];

`ifdef DECODE_BYPASS_EN
   always_comb begin
      resolved = '0;
      if (wb_en) resolved[wb_addr] = 1'b1;
   end
`else
   assign resolved = '0;
`endif

   // A pending register only blocks issue while its writeback has not arrived.
   assign blocked = pend_q & ~resolved;

   always_comb begin
      hazard = 1'b0;
      if (is_alu)     hazard = blocked[rs1] | blocked[rs2];
      else if (is_li) hazard = blocked[rd];
   end

   assign instr_ready = ~halted_q & (~op_valid_q | op_ready) & ~hazard;
   assign accept      = instr_valid & instr_ready;

   assign rs1_val = (pend_q[rs1] & resolved[rs1]) ? wb_data : regs_q[rs1];
   assign rs2_val = (pend_q[rs2] & resolved[rs2]) ? wb_data : regs_q[rs2];

   always_comb begin
      regs_d     = regs_q;
      pend_d     = pend_q;
      op_valid_d = op_valid_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      opcode_d   = opcode_q;
      dest_d     = dest_q;
      halted_d   = halted_q;
      if (op_valid_q && op_ready) op_valid_d = 1'b0;
      if (wb_en) begin
         regs_d[wb_addr] = wb_data;
         pend_d[wb_addr] = 1'b0;
      end
      // Issue is applied after writeback so a new pending set and an LI write both take priority.
      if (accept) begin
         if (is_alu) begin
            op_valid_d  = 1'b1;
            ra_d        = rs1_val;
            rb_d        = rs2_val;
            opcode_d    = instr[6:4];
            dest_d      = rs1;
            pend_d[rs1] = 1'b1;
         end else if (is_li) begin
            regs_d[rd] = DATA_W'(instr[3:0]);
         end else if (is_halt) begin
            halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
         pend_q     <= '0;
         op_valid_q <= 1'b0;
         ra_q       <= '0;
         rb_q       <= '0;
         opcode_q   <= '0;
         dest_q     <= '0;
         halted_q   <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         pend_q     <= pend_d;
         op_valid_q <= op_valid_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         opcode_q   <= opcode_d;
         dest_q     <= dest_d;
         halted_q   <= halted_d;
      end
   end

   assign op_valid = op_valid_q;
   assign ra_data  = ra_q;
   assign rb_data  = rb_q;
   assign opcode   = opcode_q;
   assign dest     = dest_q;
   assign halted   = halted_q;

endmodule

// File: tb/tb_decode_regfile.sv
// Bench for decode_regfile: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an array-based behavioural model of the register file and slot.
module tb_decode_regfile;
   localparam int DW = 8;

`ifdef DECODE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, instr_valid, op_ready, wb_en;
   logic [7:0]    instr;
   logic [1:0]    wb_addr;
   logic [DW-1:0] wb_data;
   logic          instr_ready, op_valid, halted;
   logic [DW-1:0] ra_data, rb_data;
   logic [2:0]    opcode;
   logic [1:0]    dest;

   always #5 clk = ~clk;

   decode_regfile #(.DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .op_valid(op_valid), .op_ready(op_ready),
      .ra_data(ra_data), .rb_data(rb_data), .opcode(opcode), .dest(dest),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .halted(halted)
   );

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [DW-1:0] m_r [4];
   bit            m_pend [4];
   bit            m_v, m_halt;
   logic [DW-1:0] m_ra, m_rb;
   logic [2:0]    m_opc;
   logic [1:0]    m_dest;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_blocked(input logic [1:0] idx);
      return m_pend[idx] && !(BYP && wb_en && wb_addr == idx);
   endfunction

   function automatic bit m_ready();
      bit haz;
      haz = 1'b0;
      if (!instr[7])                haz = m_blocked(instr[3:2]) || m_blocked(instr[1:0]);
      else if (instr[7:6] == 2'b10) haz = m_blocked(instr[5:4]);
      return !m_halt && (!m_v || op_ready) && !haz;
   endfunction

   function automatic logic [DW-1:0] m_read(input logic [1:0] idx);
      if (BYP && m_pend[idx] && wb_en && wb_addr == idx) return wb_data;
      return m_r[idx];
   endfunction

   task automatic model_update();
      bit acc;
      logic [DW-1:0] v1, v2;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_r[i]    = '0;
            m_pend[i] = 1'b0;
         end
         m_v = 1'b0; m_halt = 1'b0; m_ra = '0; m_rb = '0; m_opc = '0; m_dest = '0;
         return;
      end
      acc = instr_valid && m_ready();
      v1  = m_read(instr[3:2]);
      v2  = m_read(instr[1:0]);
      if (m_v && op_ready) m_v = 1'b0;
      if (wb_en) begin
         m_r[wb_addr]    = wb_data;
         m_pend[wb_addr] = 1'b0;
      end
      if (acc) begin
         if (!instr[7]) begin
            m_v = 1'b1; m_ra = v1; m_rb = v2; m_opc = instr[6:4]; m_dest = instr[3:2];
            m_pend[instr[3:2]] = 1'b1;
         end else if (instr[7:6] == 2'b10) begin
            m_r[instr[5:4]] = {4'h0, instr[3:0]};
         end else if (instr == 8'hFF) begin
            m_halt = 1'b1;
         end
      end
   endtask

   task automatic compare();
      chk("instr_ready", instr_ready, m_ready());
      chk("op_valid", op_valid, m_v);
      chk("halted", halted, m_halt);
      if (m_v) begin
         chk("ra_data", ra_data, m_ra);
         chk("rb_data", rb_data, m_rb);
         chk("opcode", opcode, m_opc);
         chk("dest", dest, m_dest);
      end
   endtask

   task automatic drive(input bit rn, input bit iv, input logic [7:0] ins, input bit ordy,
                        input bit we, input logic [1:0] wa, input logic [DW-1:0] wd, input bit do_cmp);
      @(negedge clk);
      rst_n = rn; instr_valid = iv; instr = ins; op_ready = ordy;
      wb_en = we; wb_addr = wa; wb_data = wd;
      #1;
      if (do_cmp) compare();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
   endtask

   task automatic cyc(input bit rn, input bit iv, input logic [7:0] ins, input bit ordy,
                      input bit we, input logic [1:0] wa, input logic [DW-1:0] wd);
      drive(rn, iv, ins, ordy, we, wa, wd, 1'b1);
      tick();
   endtask

   logic [7:0]    r_ins;
   logic [1:0]    r_wa;
   bit            r_rn, r_iv, r_or, r_we;
   int            pick;
   int            npend;
   logic [1:0]    plist [4];

   initial begin
      rst_n = 1'b0; instr_valid = 1'b0; instr = '0; op_ready = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;

      drive(0, 0, 8'h00, 1, 0, 0, 0, 0); tick();
      drive(0, 0, 8'h00, 1, 0, 0, 0, 0); tick();
      drive(1, 0, 8'h00, 1, 0, 0, 0, 1);
      chk("rst_op_valid", op_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_ra", ra_data, 0);
      chk("rst_rb", rb_data, 0);
      chk("rst_opcode", opcode, 0);
      chk("rst_dest", dest, 0);
      tick();

      // LI R1=5, LI R2=3, add R1,R2
      drive(1, 1, 8'h95, 1, 0, 0, 0, 1); chk("li_ready", instr_ready, 1); tick();
      cyc(1, 1, 8'hA3, 1, 0, 0, 0);
      cyc(1, 1, 8'h46, 1, 0, 0, 0);
      drive(1, 1, 8'h04, 1, 0, 0, 0, 1);
      chk("add_valid", op_valid, 1);
      chk("add_ra", ra_data, 8'h05);
      chk("add_rb", rb_data, 8'h03);
      chk("add_opcode", opcode, 3'b100);
      chk("add_dest", dest, 1);
      chk("raw_stall", instr_ready, 0);
      tick();

      // Dependent op meets the writeback of R1
      drive(1, 1, 8'h04, 1, 1, 2'd1, 8'h08, 1);
      chk("wb_same_cycle_ready", instr_ready, BYP);
      tick();
      if (!BYP) cyc(1, 1, 8'h04, 1, 0, 0, 0);
      drive(1, 0, 8'h00, 1, 0, 0, 0, 1);
      chk("dep_valid", op_valid, 1);
      chk("dep_ra", ra_data, 8'h08);
      tick();
      cyc(1, 0, 8'h00, 1, 1, 2'd1, 8'h10);

      // Back-pressure holds the slot
      cyc(1, 1, 8'h1B, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         drive(1, 1, 8'h20, 0, 0, 0, 0, 1);
         chk("bp_ready", instr_ready, 0);
         chk("bp_ra", ra_data, 8'h03);
         chk("bp_rb", rb_data, 8'h00);
         chk("bp_opcode", opcode, 3'd1);
         chk("bp_dest", dest, 2);
         tick();
      end
      drive(1, 1, 8'h20, 1, 0, 0, 0, 1); chk("bp_release_ready", instr_ready, 1); tick();
      cyc(1, 0, 8'h00, 1, 1, 2'd2, 8'h33);
      cyc(1, 0, 8'h00, 1, 1, 2'd0, 8'h44);

      // LI and writeback to the same register on one edge
      drive(1, 1, 8'h8A, 1, 1, 2'd0, 8'h55, 1); chk("li_wb_ready", instr_ready, 1); tick();
      cyc(1, 1, 8'h00, 1, 0, 0, 0);
      drive(1, 0, 8'h00, 1, 0, 0, 0, 1);
      chk("li_wins_ra", ra_data, 8'h0A);
      chk("li_wins_rb", rb_data, 8'h0A);
      tick();
      cyc(1, 0, 8'h00, 1, 1, 2'd0, 8'h01);

      // HALT with a loaded slot
      cyc(1, 1, 8'h1B, 0, 0, 0, 0);
      drive(1, 1, 8'hFF, 1, 0, 0, 0, 1); chk("halt_ready", instr_ready, 1); tick();
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, (k[0] ? 8'h95 : 8'h20), 1, 0, 0, 0, 1);
         chk("halted_sticky", halted, 1);
         chk("halted_ready", instr_ready, 0);
         chk("halt_drained", op_valid, 0);
         tick();
      end
      drive(0, 0, 8'h00, 1, 0, 0, 0, 1); tick();
      drive(1, 0, 8'h00, 1, 0, 0, 0, 1);
      chk("halt_rst_halted", halted, 0);
      chk("halt_rst_valid", op_valid, 0);
      tick();
      cyc(1, 1, 8'h01, 1, 0, 0, 0);
      drive(1, 1, 8'h1B, 1, 0, 0, 0, 1);
      chk("rst_r0", ra_data, 0);
      chk("rst_r1", rb_data, 0);
      tick();
      drive(1, 0, 8'h00, 1, 0, 0, 0, 1);
      chk("rst_r2", ra_data, 0);
      chk("rst_r3", rb_data, 0);
      tick();

      // Reset with a loaded slot and R2 pending
      cyc(1, 1, 8'h05, 0, 0, 0, 0);
      drive(0, 0, 8'h00, 0, 0, 0, 0, 1); tick();
      drive(1, 1, 8'h08, 0, 0, 0, 0, 1);
      chk("rst_mid_valid", op_valid, 0);
      chk("rst_mid_ready", instr_ready, 1);
      tick();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r_rn = ($urandom_range(0, 299) != 0);
         r_iv = ($urandom_range(0, 3) != 0);
         r_or = ($urandom_range(0, 9) < 7);
         pick = $urandom_range(0, 399);
         if (pick < 220)      r_ins = {1'b0, 7'($urandom)};
         else if (pick < 340) r_ins = {2'b10, 6'($urandom)};
         else if (pick < 399) r_ins = {2'b11, 6'($urandom_range(0, 62))};
         else                 r_ins = 8'hFF;
         npend = 0;
         for (int i = 0; i < 4; i++) if (m_pend[i]) begin plist[npend] = 2'(i); npend++; end
         r_we = 1'b0;
         r_wa = 2'($urandom);
         if (npend > 0 && $urandom_range(0, 99) < 45) begin
            r_we = 1'b1;
            r_wa = plist[$urandom_range(0, npend - 1)];
         end else if ($urandom_range(0, 99) < 5) begin
            r_we = 1'b1;
         end
         cyc(r_rn, r_iv, r_ins, r_or, r_we, r_wa, 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
